// File: rtl/mem_lower_pkg.sv
// Shared constants, FSM state type and mask helper for the tiled rf2 memory wrapper.
// Tie-off values hold the foundry macros in their functional, non-test configuration.
package mem_lower_pkg;

  localparam logic [2:0] EMA_TIE      = 3'd3;
  localparam logic       EMASA_TIE    = 1'b0;
  localparam logic       COLLDISN_TIE = 1'b1;
  localparam logic       RET1N_TIE    = 1'b1;
  localparam logic       TEN_TIE      = 1'b1;
  localparam int         MAX_LANES    = 256;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Active-low WENB bit for one data bit, taken from its mask lane.
  function automatic logic expand_mask(
    input logic [MAX_LANES-1:0] lanes,
    input int unsigned          bit_idx,
    input int unsigned          gran
  );
    return ~lanes[8'(bit_idx / gran)];
  endfunction

endpackage

// File: rtl/mem_rf2_tile.sv
// One rf2 two-port macro with its tie-offs and lane-to-bit write-enable expansion.
// The macro core below is its behavioural equivalent: registered QA, bitwise WENB.
module mem_rf2_tile
  import mem_lower_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int MASK_GRAN   = 8,
  parameter int MACRO_DEPTH = 32,
  parameter int MACRO_WIDTH = 128,
  parameter int COL_LO      = 0,
  localparam int MW    = WIDTH / MASK_GRAN,
  localparam int MAW   = $clog2(MACRO_DEPTH),
  localparam int DBITS = (WIDTH - COL_LO < MACRO_WIDTH) ?
                         (WIDTH - COL_LO) : MACRO_WIDTH
) (
  input  logic             clock,
  input  logic             cena,
  input  logic [MAW-1:0]   aa,
  input  logic             cenb,
  input  logic [MAW-1:0]   ab,
  input  logic [WIDTH-1:0] wdata,
  input  logic [MW-1:0]    wmask,
  output logic [DBITS-1:0] q
);

  logic [2:0]             emaa, emab;
  logic                   emasa, colldisn, ret1n;
  logic                   tena, tenb;
  logic [MACRO_WIDTH-1:0] twenb;
  logic [MACRO_WIDTH-1:0] db, wenb, wenb_eff, bwe, qa;
  logic                   macro_ok, cena_eff, cenb_eff;
  logic [MACRO_WIDTH-1:0] mem [MACRO_DEPTH];

  assign emaa     = EMA_TIE;
  assign emab     = EMA_TIE;
  assign emasa    = EMASA_TIE;
  assign colldisn = COLLDISN_TIE;
  assign ret1n    = RET1N_TIE;
  assign tena     = TEN_TIE;
  assign tenb     = TEN_TIE;
  assign twenb    = '1;

  for (genvar b = 0; b < MACRO_WIDTH; b++) begin : g_bit
    if (b < DBITS) begin : g_live
      assign db[b]   = wdata[COL_LO+b];
      assign wenb[b] = expand_mask(MAX_LANES'(wmask),
                                   COL_LO + b, MASK_GRAN);
    end else begin : g_pad
      assign db[b]   = 1'b0;
      assign wenb[b] = 1'b1;
    end
  end

  // Macro only responds in its functional (non-retention, non-test) mode.
  assign macro_ok = ret1n & colldisn & ~emasa &
                    (emaa != 3'd0) & (emab != 3'd0);
  assign cena_eff = cena | ~tena | ~macro_ok;
  assign cenb_eff = cenb | ~macro_ok;
  assign wenb_eff = tenb ? wenb : twenb;
  assign bwe      = ~wenb_eff;

  always_ff @(posedge clock) begin
    if (!cena_eff) qa <= mem[aa];
    if (!cenb_eff) mem[ab] <= (mem[ab] & ~bwe) | (db & bwe);
  end

  assign q = qa[DBITS-1:0];

endmodule

// File: rtl/mem_1r1w_masked_tiled.sv
// 1R1W byte-masked memory tiled over rf2 macros, zero-swept after reset, with forwarding.
// Define MEM_OUT_REG_EN for an extra output register stage (read latency 2).
module mem_1r1w_masked_tiled
  import mem_lower_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WIDTH       = 64,
  parameter int MASK_GRAN   = 8,
  parameter int MACRO_DEPTH = 32,
  parameter int MACRO_WIDTH = 128,
  localparam int AW = $clog2(DEPTH),
  localparam int MW = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             init_done,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [MW-1:0]    W0_mask
);

  localparam int MAW  = $clog2(MACRO_DEPTH);
  localparam int ROWS = (DEPTH + MACRO_DEPTH - 1) / MACRO_DEPTH;
  localparam int COLS = (WIDTH + MACRO_WIDTH - 1) / MACRO_WIDTH;

  state_t         state_q, state_d;
  logic [MAW-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + MAW'(1);
        if (init_cnt_q == MAW'(MACRO_DEPTH - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  logic run, r_in, w_in, r_acc, w_acc, coll;

  assign run       = (state_q == RUN);
  assign init_done = run;
  assign r_in  = {1'b0, R0_addr} < (AW+1)'(DEPTH);
  assign w_in  = {1'b0, W0_addr} < (AW+1)'(DEPTH);
  assign r_acc = run & R0_en;
  assign w_acc = run & W0_en & w_in;
  assign coll  = r_acc & r_in & W0_en & (R0_addr == W0_addr);

  logic [ROWS-1:0]  cena_row, cenb_row;
  logic [MAW-1:0]   waddr_m;
  logic [WIDTH-1:0] wdata_m;
  logic [MW-1:0]    wmask_m;

  // The init sweep writes every row at once; in RUN only the addressed row.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      cena_row[r] = ~(r_acc & r_in & ((R0_addr >> MAW) == AW'(r)));
      cenb_row[r] = run ? ~(w_acc & ((W0_addr >> MAW) == AW'(r))) : 1'b0;
    end
  end

  assign waddr_m = run ? W0_addr[MAW-1:0] : init_cnt_q;
  assign wdata_m = run ? W0_data : '0;
  assign wmask_m = run ? W0_mask : '1;

  logic [WIDTH-1:0] row_q [ROWS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int LO = c * MACRO_WIDTH;
      localparam int NB = (WIDTH - LO < MACRO_WIDTH) ?
                          (WIDTH - LO) : MACRO_WIDTH;
      mem_rf2_tile #(
        .WIDTH       (WIDTH),
        .MASK_GRAN   (MASK_GRAN),
        .MACRO_DEPTH (MACRO_DEPTH),
        .MACRO_WIDTH (MACRO_WIDTH),
        .COL_LO      (LO)
      ) u_tile (
        .clock (clock),
        .cena  (cena_row[r]),
        .aa    (R0_addr[MAW-1:0]),
        .cenb  (cenb_row[r]),
        .ab    (waddr_m),
        .wdata (wdata_m),
        .wmask (wmask_m),
        .q     (row_q[r][LO +: NB])
      );
    end
  end

  logic             valid1_q, rd_zero_q;
  logic [AW-1:0]    sel_row_q;
  logic [MW-1:0]    fwd_mask_q;
  logic [WIDTH-1:0] fwd_data_q, rd_word, data1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid1_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
      sel_row_q  <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      valid1_q <= r_acc;
      if (r_acc) begin
        sel_row_q  <= R0_addr >> MAW;
        rd_zero_q  <= ~r_in;
        fwd_mask_q <= coll ? W0_mask : '0;
        fwd_data_q <= W0_data;
      end
    end
  end

  // Selection registers only move on a read, so the output holds between reads.
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < ROWS; r++)
      if (sel_row_q == AW'(r)) rd_word = row_q[r];
    data1 = rd_word;
    for (int i = 0; i < MW; i++)
      if (fwd_mask_q[i])
        data1[i*MASK_GRAN +: MASK_GRAN] = fwd_data_q[i*MASK_GRAN +: MASK_GRAN];
    if (rd_zero_q) data1 = '0;
  end

`ifdef MEM_OUT_REG_EN
  logic             valid2_q;
  logic [WIDTH-1:0] data2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid2_q <= 1'b0;
      data2_q  <= '0;
    end else begin
      valid2_q <= valid1_q;
      data2_q  <= data1;
    end
  end

  assign R0_valid = valid2_q;
  assign R0_data  = data2_q;
`else
  assign R0_valid = valid1_q;
  assign R0_data  = data1;
`endif

endmodule

// File: tb/tb_mem_1r1w_masked_tiled.sv
// Bench for mem_1r1w_masked_tiled: word-array model plus directed literal checks.
// Latency follows MEM_OUT_REG_EN.
module tb_mem_1r1w_masked_tiled;

  localparam int DEPTH = 256;
  localparam int MD    = 32;
`ifdef MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        init_done;
  logic [7:0]  R0_addr = '0;
  logic        R0_en = 1'b0;
  logic [63:0] R0_data;
  logic        R0_valid;
  logic [7:0]  W0_addr = '0;
  logic        W0_en = 1'b0;
  logic [63:0] W0_data = '0;
  logic [7:0]  W0_mask = '0;

  int vectors = 0;
  int miscompares = 0;
  bit cen_chk = 1'b0;

  always #5 clock = ~clock;

  mem_1r1w_masked_tiled dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .init_done (init_done),
    .R0_addr   (R0_addr),
    .R0_en     (R0_en),
    .R0_data   (R0_data),
    .R0_valid  (R0_valid),
    .W0_addr   (W0_addr),
    .W0_en     (W0_en),
    .W0_data   (W0_data),
    .W0_mask   (W0_mask)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  logic [63:0] m_mem [DEPTH];
  int          m_init_left = 0;
  bit          m_v [LAT];
  logic [63:0] m_d [LAT];
  bit          m_out_v = 1'b0;
  logic [63:0] m_out_d = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_init_left = MD;
      foreach (m_mem[i]) m_mem[i] = '0;
      for (int k = 0; k < LAT; k++) begin
        m_v[k] = 1'b0;
        m_d[k] = '0;
      end
      m_out_v = 1'b0;
      m_out_d = '0;
    end else begin
      bit          nv;
      logic [63:0] nd;
      nv = 1'b0;
      nd = '0;
      if (m_init_left > 0) begin
        m_init_left--;
      end else begin
        if (R0_en) begin
          nv = 1'b1;
          nd = (int'(R0_addr) < DEPTH) ? m_mem[R0_addr] : 64'd0;
          if (W0_en && W0_addr == R0_addr)
            for (int l = 0; l < 8; l++)
              if (W0_mask[l]) nd[l*8 +: 8] = W0_data[l*8 +: 8];
        end
        if (W0_en && int'(W0_addr) < DEPTH)
          for (int l = 0; l < 8; l++)
            if (W0_mask[l]) m_mem[W0_addr][l*8 +: 8] = W0_data[l*8 +: 8];
      end
      for (int k = LAT - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1];
        m_d[k] = m_d[k-1];
      end
      m_v[0] = nv;
      m_d[0] = nd;
      m_out_v = m_v[LAT-1];
      if (m_v[LAT-1]) m_out_d = m_d[LAT-1];
    end
  end

  always @(negedge clock) begin
    check("init_done", {63'd0, init_done}, {63'd0, m_init_left == 0});
    check("R0_valid", {63'd0, R0_valid}, {63'd0, m_out_v});
    check("R0_data", R0_data, m_out_d);
  end

  task automatic drive(input bit re, input logic [7:0] ra,
                       input bit we, input logic [7:0] wa,
                       input logic [63:0] wd, input logic [7:0] wm);
    R0_en = re; R0_addr = ra;
    W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm;
    #1;
    if (cen_chk && m_init_left == 0) begin
      check("cena_row", {56'd0, dut.cena_row},
            re ? {56'd0, ~(8'd1 << ra[7:5])} : 64'hFF);
      check("cenb_row", {56'd0, dut.cenb_row},
            we ? {56'd0, ~(8'd1 << wa[7:5])} : 64'hFF);
    end
    @(posedge clock); #1;
    R0_en = 1'b0;
    W0_en = 1'b0;
  endtask

  task automatic wait_lat();
    repeat (LAT - 1) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic read_chk(input logic [7:0] a, input logic [63:0] exp,
                          input string nm);
    drive(1'b1, a, 1'b0, 8'd0, 64'd0, 8'd0);
    wait_lat();
    check(nm, R0_data, exp);
    check({nm, "_valid"}, {63'd0, R0_valid}, 64'd1);
  endtask

  task automatic wait_init(input string nm, input bit poke);
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      if (poke) drive(1'b1, 8'd10, 1'b1, 8'd10, 64'hFFFF, 8'hFF);
      else begin
        @(posedge clock); #1;
      end
      n++;
    end
    check(nm, 64'(n), 64'd32);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    wait_init("init_rise", 1'b0);

    for (int a = 0; a < DEPTH; a++)
      drive(1'b1, 8'(a), 1'b0, 8'd0, 64'd0, 8'd0);
    wait_lat();
    read_chk(8'd200, 64'd0, "sweep_zero");

    drive(1'b0, 8'd0, 1'b1, 8'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    drive(1'b0, 8'd0, 1'b1, 8'd5, 64'd0, 8'h0F);
    read_chk(8'd5, 64'hDEADBEEF_00000000, "masked_wr");

    drive(1'b0, 8'd0, 1'b1, 8'd7, 64'h11111111_11111111, 8'hFF);
    drive(1'b1, 8'd7, 1'b1, 8'd7, 64'hAAAAAAAA_AAAAAAAA, 8'hF0);
    wait_lat();
    check("collision", R0_data, 64'hAAAAAAAA_11111111);
    read_chk(8'd7, 64'hAAAAAAAA_11111111, "coll_mem");

    cen_chk = 1'b1;
    drive(1'b0, 8'd0, 1'b1, 8'd31, 64'd1, 8'hFF);
    drive(1'b0, 8'd0, 1'b1, 8'd32, 64'd2, 8'hFF);
    drive(1'b0, 8'd0, 1'b1, 8'd255, 64'd3, 8'hFF);
    read_chk(8'd31, 64'd1, "row_edge31");
    read_chk(8'd32, 64'd2, "row_edge32");
    read_chk(8'd255, 64'd3, "row_top255");
    drive(1'b1, 8'd5, 1'b1, 8'd40, 64'h55, 8'hFF);
    read_chk(8'd40, 64'h55, "indep_wr");
    cen_chk = 1'b0;

    drive(1'b1, 8'd31, 1'b0, 8'd0, 64'd0, 8'd0);
    drive(1'b1, 8'd32, 1'b0, 8'd0, 64'd0, 8'd0);
    drive(1'b1, 8'd255, 1'b0, 8'd0, 64'd0, 8'd0);
    wait_lat();
    check("stream_last", R0_data, 64'd3);
    repeat (2) @(posedge clock);
    #1;

    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++)
      drive(1'b1, 8'd9, 1'b1, 8'd9, 64'hFFFF_FFFF, 8'hFF);
    check("init_cnt", 64'(dut.init_cnt_q), 64'd10);
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    wait_init("restart_rise", 1'b1);
    read_chk(8'd9, 64'd0, "init_drop9");
    read_chk(8'd10, 64'd0, "init_drop10");
    read_chk(8'd5, 64'd0, "reswept5");

    repeat (3) @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
